lenet_layer_sequencer: RTL and testbench
========================================

# lenet_layer_sequencer

Sequences the absolute-value weight SRAM reader through LeNet layers 1→2→3 for one inference. On each `start` it drives the reader's one-hot `layer` select and `state_changed` pulse, then monitors the reader's `data_valid` stream to detect end-of-layer. It waits for the downstream layer-complete acknowledge before advancing, and flags beat-count mismatches and timeouts. It sits between the inference control plane and the weight reader.

## Interface
- `PREAMBLE_CYCLE_LENGTH`, 10, preamble beats the reader emits before weights
- `LAYER1_CYCLES`, 14700, expected weight beats for layer 1
- `LAYER2_CYCLES`, 1900, expected weight beats for layer 2
- `LAYER3_CYCLES`, 70, expected weight beats for layer 3
- `TIMEOUT_CYCLES`, 65535, maximum cycles in any wait state
- `CNT_W`, 16, beat/timeout counter width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle inference request
- `abort`  in  1  one-cycle cancel
- `weight_valid`  in  1  reader `data_valid`
- `layer_ack`  in  1  downstream pulse: current layer's accumulation/activation finished
- `layer`  out  3  one-hot layer select to reader
- `state_changed`  out  1  one-cycle arm pulse to reader
- `busy`  out  1  high from accepted `start` until DONE/abort
- `done`  out  1  one-cycle pulse: all three layers acknowledged
- `err`  out  1  sticky error, cleared by next accepted `start`
- `err_code`  out  2  0 none, 1 beat-count mismatch, 2 timeout, 3 abort
- `beat_count`  out  CNT_W  valid beats seen in last completed layer

## Operation
- States: IDLE, ARM, WAIT_VALID, STREAM, WAIT_ACK, NEXT, DONE.
- IDLE: `layer`=000. `start` → ARM, `layer`←001, clear `err`/`err_code`.
- ARM (1 cycle): `state_changed`=1; → WAIT_VALID; clear beat and timeout counters.
- WAIT_VALID: `weight_valid`=1 → STREAM, count that beat.
- STREAM: count every `weight_valid`=1 beat; first `weight_valid`=0 → WAIT_ACK, latch `beat_count`; if count ≠ PREAMBLE_CYCLE_LENGTH + LAYERn_CYCLES, set `err`, `err_code`=1, continue (non-fatal).
- WAIT_ACK: `layer` held; `layer_ack` → NEXT. `layer_ack` in other states ignored.
- NEXT (1 cycle): if `layer`=100 → DONE, else `layer`←`layer`<<1 and → ARM.
- DONE (1 cycle): `done`=1, `layer`←000, → IDLE.
- Timeout: WAIT_VALID, STREAM or WAIT_ACK exceeding TIMEOUT_CYCLES → `err`, `err_code`=2, → IDLE.
- `abort` in any non-IDLE state → IDLE, `layer`=000, `err`, `err_code`=3; no `done`. `abort` has priority over all other events in that cycle.
- `start` while `busy` ignored. `start` and `abort` together in IDLE: `abort` ignored, `start` accepted.
- Counters saturate at 2^CNT_W−1; saturation ⇒ mismatch.

## Timing
- Reset: `layer`=000, `state_changed`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0, `beat_count`=0, state IDLE. `rst` mid-layer aborts immediately, no `done`/`err`.
- `start` at cycle t: `layer`=001 and `busy`=1 at t+1; `state_changed`=1 at t+1 only.
- `layer` is registered, stable from ARM through WAIT_ACK; changes only on NEXT/DONE/abort/rst edges.
- `layer_ack` at t → next `state_changed` pulse at t+2 (NEXT, then ARM).
- Final `layer_ack` at t → `done` at t+2; `busy` low at t+3.
- All outputs registered; no combinational input→output paths.

## Structure
- Shared package `lightning_seq_pkg`: state enum, one-hot layer constants (L1=001, L2=010, L3=100), err_code constants. Reuse in other model sequencers.
- One sub-module natural: `seq_beat_counter` (clear, enable, saturating count, compare-to-expected, timeout flag), instantiated twice (beats, timeout).

## Test plan
- Nominal: `start`, reader model emits 14710/1910/80 valid beats, `layer_ack` 5 cycles after each → `layer` 001→010→100, three `state_changed` pulses, `done` once, `err`=0.
- Mismatch: layer 2 emits 1909 beats → `err`=1, `err_code`=1, `beat_count`=1909, sequence still completes with `done`.
- Timeout: `TIMEOUT_CYCLES`=100, no `weight_valid` after ARM → `err_code`=2 at 101st wait cycle, `layer`=000, `busy`=0.
- Abort in layer 2 STREAM → next cycle `layer`=000, `err_code`=3, no `done`; subsequent `start` clears `err`.
- `start` pulsed during STREAM and `layer_ack` pulsed during STREAM → both ignored, no extra `state_changed`.
- `rst` asserted mid layer 1 → all outputs at reset values next cycle; fresh `start` runs nominally.

Source files
------------

// File: rtl/lightning_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lightning_seq_pkg
//  Description : Shared types and constants for the model layer sequencers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lightning_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_WAIT_VALID = 3'd2,
        S_STREAM     = 3'd3,
        S_WAIT_ACK   = 3'd4,
        S_NEXT       = 3'd5,
        S_DONE       = 3'd6
    } seq_state_t;

    localparam logic [2:0] c_layer_none = 3'b000;
    localparam logic [2:0] c_layer_l1   = 3'b001;
    localparam logic [2:0] c_layer_l2   = 3'b010;
    localparam logic [2:0] c_layer_l3   = 3'b100;

    localparam logic [1:0] c_err_none     = 2'd0;
    localparam logic [1:0] c_err_mismatch = 2'd1;
    localparam logic [1:0] c_err_timeout  = 2'd2;
    localparam logic [1:0] c_err_abort    = 2'd3;

    // One-hot advance to the following layer.
    function automatic logic [2:0] layer_advance(input logic [2:0] layer_now);
        return {layer_now[1:0], 1'b0};
    endfunction

endpackage : lightning_seq_pkg
`default_nettype wire

// File: rtl/seq_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_beat_counter
//  Description : Clearable saturating counter with compare-to-limit flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_beat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_match
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A saturated count no longer represents a true tally, so it never matches.
    assign o_count = r_count;
    assign o_match = (r_count == i_limit) && (r_count != c_cnt_max);

endmodule : seq_beat_counter
`default_nettype wire

// File: rtl/lenet_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_layer_sequencer
//  Description : Walks the weight reader through LeNet layers 1-3 per inference.
//  Revision    : 1.0 - initial release
// ============================================================================
module lenet_layer_sequencer
    import lightning_seq_pkg::*;
#(
    parameter int PREAMBLE_CYCLE_LENGTH = 10,
    parameter int LAYER1_CYCLES         = 14700,
    parameter int LAYER2_CYCLES         = 1900,
    parameter int LAYER3_CYCLES         = 70,
    parameter int TIMEOUT_CYCLES        = 65535,
    parameter int CNT_W                 = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             weight_valid,
    input  logic             layer_ack,
    output logic [2:0]       layer,
    output logic             state_changed,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] beat_count
);

    localparam logic [CNT_W-1:0] c_exp_l1  = CNT_W'(PREAMBLE_CYCLE_LENGTH + LAYER1_CYCLES);
    localparam logic [CNT_W-1:0] c_exp_l2  = CNT_W'(PREAMBLE_CYCLE_LENGTH + LAYER2_CYCLES);
    localparam logic [CNT_W-1:0] c_exp_l3  = CNT_W'(PREAMBLE_CYCLE_LENGTH + LAYER3_CYCLES);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [2:0]       r_layer;
    logic [2:0]       w_layer_next;
    logic             r_state_changed;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_err_next;
    logic [1:0]       r_err_code;
    logic [1:0]       w_err_code_next;
    logic [CNT_W-1:0] r_beat_count;
    logic [CNT_W-1:0] w_beat_count_next;

    logic             w_beat_clr;
    logic             w_beat_en;
    logic [CNT_W-1:0] w_beat_cnt;
    logic             w_beat_match;
    logic [CNT_W-1:0] w_expected;

    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic [CNT_W-1:0] w_tmr_cnt;
    logic             w_tmr_match;
    logic             w_timeout;

    seq_beat_counter #(
        .CNT_W (CNT_W)
    ) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_beat_clr),
        .i_enable (w_beat_en),
        .i_limit  (w_expected),
        .o_count  (w_beat_cnt),
        .o_match  (w_beat_match)
    );

    seq_beat_counter #(
        .CNT_W (CNT_W)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_tmr_clr),
        .i_enable (w_tmr_en),
        .i_limit  (c_timeout),
        .o_count  (w_tmr_cnt),
        .o_match  (w_tmr_match)
    );

    // A saturated timer means the limit sits at the counter ceiling.
    assign w_timeout = w_tmr_match || (w_tmr_cnt == c_cnt_max);

    always_comb begin
        w_expected = c_exp_l1;
        case (r_layer)
            c_layer_l2: w_expected = c_exp_l2;
            c_layer_l3: w_expected = c_exp_l3;
            default:    w_expected = c_exp_l1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_layer         <= c_layer_none;
            r_state_changed <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_err_code      <= c_err_none;
            r_beat_count    <= '0;
        end else begin
            r_state         <= w_state_next;
            r_layer         <= w_layer_next;
            r_state_changed <= (w_state_next == S_ARM);
            r_busy          <= (w_state_next != S_IDLE);
            r_done          <= (w_state_next == S_DONE);
            r_err           <= w_err_next;
            r_err_code      <= w_err_code_next;
            r_beat_count    <= w_beat_count_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_layer_next      = r_layer;
        w_err_next        = r_err;
        w_err_code_next   = r_err_code;
        w_beat_count_next = r_beat_count;
        w_beat_clr        = 1'b0;
        w_beat_en         = 1'b0;
        w_tmr_clr         = 1'b0;
        w_tmr_en          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next    = S_ARM;
                    w_layer_next    = c_layer_l1;
                    w_err_next      = 1'b0;
                    w_err_code_next = c_err_none;
                end
            end
            S_ARM: begin
                w_state_next = S_WAIT_VALID;
                w_beat_clr   = 1'b1;
                w_tmr_clr    = 1'b1;
            end
            S_WAIT_VALID: begin
                w_tmr_en = 1'b1;
                if (weight_valid) begin
                    w_state_next = S_STREAM;
                    w_beat_en    = 1'b1;
                    w_tmr_clr    = 1'b1;
                end else if (w_timeout) begin
                    w_state_next    = S_IDLE;
                    w_layer_next    = c_layer_none;
                    w_err_next      = 1'b1;
                    w_err_code_next = c_err_timeout;
                end
            end
            S_STREAM: begin
                // Every beat is progress, so the wait timer restarts per beat.
                w_tmr_en = 1'b1;
                if (weight_valid) begin
                    w_beat_en = 1'b1;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_state_next      = S_WAIT_ACK;
                    w_beat_count_next = w_beat_cnt;
                    w_tmr_clr         = 1'b1;
                    if (!w_beat_match) begin
                        w_err_next      = 1'b1;
                        w_err_code_next = c_err_mismatch;
                    end
                end
            end
            S_WAIT_ACK: begin
                w_tmr_en = 1'b1;
                if (layer_ack) begin
                    w_state_next = S_NEXT;
                end else if (w_timeout) begin
                    w_state_next    = S_IDLE;
                    w_layer_next    = c_layer_none;
                    w_err_next      = 1'b1;
                    w_err_code_next = c_err_timeout;
                end
            end
            S_NEXT: begin
                if (r_layer == c_layer_l3) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ARM;
                    w_layer_next = layer_advance(r_layer);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_layer_next = c_layer_none;
            end
            default: begin
                w_state_next = S_IDLE;
                w_layer_next = c_layer_none;
            end
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (abort && (r_state != S_IDLE)) begin
            w_state_next    = S_IDLE;
            w_layer_next    = c_layer_none;
            w_err_next      = 1'b1;
            w_err_code_next = c_err_abort;
        end
    end

    assign layer         = r_layer;
    assign state_changed = r_state_changed;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign beat_count    = r_beat_count;

endmodule : lenet_layer_sequencer
`default_nettype wire

// File: tb/tb_lenet_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lenet_layer_sequencer
//  Description : Directed/randomized self-checking bench for the layer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lenet_layer_sequencer;

    localparam int PRE = 10;
    localparam int L1  = 14700;
    localparam int L2  = 1900;
    localparam int L3  = 70;
    localparam int TO  = 100;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          weight_valid = 1'b0;
    logic          layer_ack = 1'b0;
    logic [2:0]    layer;
    logic          state_changed;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [CW-1:0] beat_count;

    int n_vec  = 0;
    int n_err  = 0;
    int n_sc   = 0;
    int n_done = 0;

    // Reference model: expected beats per layer and the sticky error state.
    int         exp_beats [3] = '{PRE + L1, PRE + L2, PRE + L3};
    logic       m_err;
    logic [1:0] m_code;

    lenet_layer_sequencer #(
        .PREAMBLE_CYCLE_LENGTH (PRE),
        .LAYER1_CYCLES         (L1),
        .LAYER2_CYCLES         (L2),
        .LAYER3_CYCLES         (L3),
        .TIMEOUT_CYCLES        (TO),
        .CNT_W                 (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .weight_valid  (weight_valid),
        .layer_ack     (layer_ack),
        .layer         (layer),
        .state_changed (state_changed),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .beat_count    (beat_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (state_changed === 1'b1) n_sc++;
        if (done === 1'b1) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_layer"}, 32'(layer), 0);
        chk({tag, "_sc"}, 32'(state_changed), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_code"}, 32'(err_code), 0);
        chk({tag, "_beats"}, 32'(beat_count), 0);
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_err  = 1'b0;
        m_code = 2'd0;
        chk("start_layer", 32'(layer), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_sc", 32'(state_changed), 1);
        chk("start_err", 32'(err), 0);
        chk("start_code", 32'(err_code), 0);
    endtask

    // Enters with the DUT in ARM; leaves in the next ARM, or in IDLE after the last layer.
    task automatic do_layer(input int idx, input int n, input bit last, input bit glitch);
        int gap;
        int ackd;
        int g;
        int sc0;
        gap  = int'($urandom_range(0, 4));
        ackd = int'($urandom_range(0, 6));
        g    = glitch ? int'($urandom_range(1, n - 2)) : -1;
        weight_valid = 1'b0;
        tick();
        repeat (gap) tick();
        sc0 = n_sc;
        for (int i = 0; i < n; i++) begin
            weight_valid = 1'b1;
            if (i == g) begin
                start     = 1'b1;
                layer_ack = 1'b1;
            end
            tick();
            start     = 1'b0;
            layer_ack = 1'b0;
        end
        weight_valid = 1'b0;
        tick();
        if (n != exp_beats[idx]) begin
            m_err  = 1'b1;
            m_code = 2'd1;
        end
        chk("beat_count", 32'(beat_count), 32'(n));
        chk("layer_err", 32'(err), 32'(m_err));
        chk("layer_code", 32'(err_code), 32'(m_code));
        chk("layer_held", 32'(layer), 32'(1 << idx));
        chk("no_extra_sc", 32'(n_sc), 32'(sc0));
        repeat (ackd) tick();
        layer_ack = 1'b1;
        tick();
        layer_ack = 1'b0;
        chk("next_sc", 32'(state_changed), 0);
        tick();
        if (!last) begin
            chk("arm_sc", 32'(state_changed), 1);
            chk("arm_layer", 32'(layer), 32'(1 << (idx + 1)));
        end else begin
            chk("done_pulse", 32'(done), 1);
            chk("done_layer", 32'(layer), 32'(4));
            chk("done_busy", 32'(busy), 1);
            tick();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_layer", 32'(layer), 0);
            chk("final_err", 32'(err), 32'(m_err));
            chk("final_code", 32'(err_code), 32'(m_code));
        end
    endtask

    initial begin
        int sc0;
        int d0;
        int k;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Nominal inference with start/ack glitches inside the layer-2 stream
        sc0 = n_sc;
        d0  = n_done;
        start_run();
        do_layer(0, exp_beats[0], 1'b0, 1'b0);
        do_layer(1, exp_beats[1], 1'b0, 1'b1);
        do_layer(2, exp_beats[2], 1'b1, 1'b0);
        chk("nominal_sc_total", 32'(n_sc - sc0), 3);
        chk("nominal_done_total", 32'(n_done - d0), 1);

        // Layer 2 one beat short: non-fatal mismatch, still completes
        d0 = n_done;
        start_run();
        do_layer(0, exp_beats[0], 1'b0, 1'b0);
        do_layer(1, exp_beats[1] - 1, 1'b0, 1'b0);
        do_layer(2, exp_beats[2], 1'b1, 1'b0);
        chk("mismatch_done_total", 32'(n_done - d0), 1);

        // Abort in the middle of the layer-2 stream
        start_run();
        do_layer(0, exp_beats[0], 1'b0, 1'b0);
        weight_valid = 1'b0;
        tick();
        k = int'($urandom_range(1, exp_beats[1] - 2));
        for (int i = 0; i < k; i++) begin
            weight_valid = 1'b1;
            tick();
        end
        abort = 1'b1;
        tick();
        abort        = 1'b0;
        weight_valid = 1'b0;
        d0 = n_done;
        chk("abort_layer", 32'(layer), 0);
        chk("abort_err", 32'(err), 1);
        chk("abort_code", 32'(err_code), 3);
        chk("abort_busy", 32'(busy), 0);
        repeat (5) tick();
        chk("abort_no_done", 32'(n_done), 32'(d0));

        // start together with abort in IDLE: start wins and clears the error
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("restart_layer", 32'(layer), 1);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_err", 32'(err), 0);
        chk("restart_code", 32'(err_code), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_arm_code", 32'(err_code), 3);

        // Timeout: no weight_valid after ARM
        start_run();
        weight_valid = 1'b0;
        for (int i = 1; i <= TO + 1; i++) tick();
        chk("timeout_pending_err", 32'(err), 0);
        chk("timeout_pending_busy", 32'(busy), 1);
        tick();
        chk("timeout_err", 32'(err), 1);
        chk("timeout_code", 32'(err_code), 2);
        chk("timeout_layer", 32'(layer), 0);
        chk("timeout_busy", 32'(busy), 0);

        // Synchronous reset in the middle of layer 1, then a fresh run
        start_run();
        weight_valid = 1'b0;
        tick();
        k = int'($urandom_range(20, 200));
        for (int i = 0; i < k; i++) begin
            weight_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        weight_valid = 1'b0;
        chk_reset_outputs("midrst");
        tick();
        d0 = n_done;
        start_run();
        do_layer(0, exp_beats[0], 1'b0, 1'b0);
        do_layer(1, exp_beats[1], 1'b0, 1'b0);
        do_layer(2, exp_beats[2], 1'b1, 1'b0);
        chk("post_rst_done_total", 32'(n_done - d0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lenet_layer_sequencer
`default_nettype wire
